// File: rtl/sccb_responder.sv
`default_nettype none
// ============================================================================
// Module   : sccb_responder
// Brief    : SCCB target emulating the OV7670 register port. It holds an
//            8-bit register array, supports auto-increment writes and
//            two-phase reads, and pulls SIOD low for ACK and read zeros.
// Revision : 1.0 - initial release
// ============================================================================
module sccb_responder #(
    parameter logic [7:0] DEVICE_ID = 8'h42,
    parameter int         ADDR_W    = 8,
    parameter bit         ACK_EN    = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sioc_in,
    input  logic              siod_in,
    output logic              siod_oe,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [7:0]        dbg_data,
    output logic              busy
);

    localparam int              c_DEPTH = 2 ** ADDR_W;
    localparam logic [7:0]      c_RD_ID = DEVICE_ID | 8'h01;
    localparam logic [ADDR_W-1:0] c_ONE = 1;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ID        = 4'd1,
        S_ID_ACK    = 4'd2,
        S_SUB       = 4'd3,
        S_SUB_ACK   = 4'd4,
        S_WDATA     = 4'd5,
        S_WDATA_ACK = 4'd6,
        S_RDATA     = 4'd7,
        S_RD_NA     = 4'd8,
        S_IGNORE    = 4'd9
    } state_t;

    // Synchronisers idle high so reset release never looks like START.
    logic [1:0] r_sioc_sync;
    logic [1:0] r_siod_sync;
    logic       r_sioc_d;
    logic       r_siod_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sioc_sync <= 2'b11;
            r_siod_sync <= 2'b11;
            r_sioc_d    <= 1'b1;
            r_siod_d    <= 1'b1;
        end else begin
            r_sioc_sync <= {r_sioc_sync[0], sioc_in};
            r_siod_sync <= {r_siod_sync[0], siod_in};
            r_sioc_d    <= r_sioc_sync[1];
            r_siod_d    <= r_siod_sync[1];
        end
    end

    logic w_sioc;
    logic w_siod;
    logic w_rise;
    logic w_fall;
    logic w_start;
    logic w_stop;

    assign w_sioc  = r_sioc_sync[1];
    assign w_siod  = r_siod_sync[1];
    assign w_rise  = w_sioc & ~r_sioc_d;
    assign w_fall  = ~w_sioc & r_sioc_d;
    assign w_start = w_sioc & r_sioc_d & r_siod_d & ~w_siod;
    assign w_stop  = w_sioc & r_sioc_d & ~r_siod_d & w_siod;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic [7:0]        r_shift;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_oe;
    logic              r_rd;
    logic              r_busy;
    logic              r_strobe;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
    logic [7:0]        r_mem [c_DEPTH];

    state_t            w_state_nxt;
    logic [3:0]        w_cnt_nxt;
    logic [7:0]        w_shift_nxt;
    logic [ADDR_W-1:0] w_ptr_nxt;
    logic              w_oe_nxt;
    logic              w_rd_nxt;
    logic              w_busy_nxt;
    logic              w_strobe_nxt;
    logic [ADDR_W-1:0] w_wr_addr_nxt;
    logic [7:0]        w_wr_data_nxt;
    logic              w_mem_we;
    logic [7:0]        w_byte;
    logic              w_byte_done;
    logic [7:0]        w_rd_word;

    assign w_byte      = {r_shift[6:0], w_siod};
    assign w_byte_done = w_rise && (r_cnt == 4'd7);
    assign w_rd_word   = r_mem[r_ptr];

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_shift_nxt   = r_shift;
        w_ptr_nxt     = r_ptr;
        w_oe_nxt      = r_oe;
        w_rd_nxt      = r_rd;
        w_busy_nxt    = r_busy;
        w_strobe_nxt  = 1'b0;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        w_mem_we      = 1'b0;

        if (w_stop) begin
            w_state_nxt = S_IDLE;
            w_oe_nxt    = 1'b0;
            w_busy_nxt  = 1'b0;
        end else if (w_start) begin
            w_state_nxt = S_ID;
            w_cnt_nxt   = 4'd0;
            w_oe_nxt    = 1'b0;
            w_rd_nxt    = 1'b0;
            w_busy_nxt  = 1'b1;
        end else begin
            case (r_state)
                S_ID, S_SUB, S_WDATA: begin
                    if (w_rise) begin
                        w_shift_nxt = w_byte;
                        w_cnt_nxt   = r_cnt + 4'd1;
                    end
                    if (w_byte_done) begin
                        w_cnt_nxt = 4'd0;
                        if (r_state == S_ID) begin
                            if (w_byte == DEVICE_ID) begin
                                w_state_nxt = S_ID_ACK;
                                w_rd_nxt    = 1'b0;
                            end else if (w_byte == c_RD_ID) begin
                                w_state_nxt = S_ID_ACK;
                                w_rd_nxt    = 1'b1;
                            end else begin
                                w_state_nxt = S_IGNORE;
                            end
                        end else if (r_state == S_SUB) begin
                            w_ptr_nxt   = w_byte[ADDR_W-1:0];
                            w_state_nxt = S_SUB_ACK;
                        end else begin
                            w_mem_we      = 1'b1;
                            w_strobe_nxt  = 1'b1;
                            w_wr_addr_nxt = r_ptr;
                            w_wr_data_nxt = w_byte;
                            w_ptr_nxt     = r_ptr + c_ONE;
                            w_state_nxt   = S_WDATA_ACK;
                        end
                    end
                end
                // r_cnt marks whether the 9th rising edge has been seen.
                S_ID_ACK, S_SUB_ACK, S_WDATA_ACK: begin
                    if (w_rise) begin
                        w_cnt_nxt = 4'd1;
                    end
                    if (w_fall) begin
                        if (r_cnt == 4'd0) begin
                            w_oe_nxt = ACK_EN;
                        end else begin
                            w_oe_nxt  = 1'b0;
                            w_cnt_nxt = 4'd0;
                            if (r_state == S_ID_ACK && r_rd) begin
                                w_state_nxt = S_RDATA;
                                w_shift_nxt = w_rd_word;
                                w_oe_nxt    = ~w_rd_word[7];
                            end else if (r_state == S_ID_ACK) begin
                                w_state_nxt = S_SUB;
                            end else begin
                                w_state_nxt = S_WDATA;
                            end
                        end
                    end
                end
                S_RDATA: begin
                    if (w_rise) begin
                        w_shift_nxt = {r_shift[6:0], 1'b0};
                        w_cnt_nxt   = r_cnt + 4'd1;
                        if (r_cnt == 4'd7) begin
                            w_cnt_nxt   = 4'd0;
                            w_state_nxt = S_RD_NA;
                        end
                    end
                    if (w_fall) begin
                        w_oe_nxt = ~r_shift[7];
                    end
                end
                S_RD_NA: begin
                    if (w_fall && r_cnt == 4'd0) begin
                        w_oe_nxt = 1'b0;
                    end
                    if (w_rise) begin
                        if (!w_siod) begin
                            w_ptr_nxt = r_ptr + c_ONE;
                            w_cnt_nxt = 4'd1;
                        end else begin
                            w_state_nxt = S_IGNORE;
                        end
                    end
                    if (w_fall && r_cnt == 4'd1) begin
                        w_cnt_nxt   = 4'd0;
                        w_shift_nxt = w_rd_word;
                        w_oe_nxt    = ~w_rd_word[7];
                        w_state_nxt = S_RDATA;
                    end
                end
                S_IDLE, S_IGNORE: begin
                    w_oe_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_oe_nxt    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_shift   <= 8'd0;
            r_ptr     <= '0;
            r_oe      <= 1'b0;
            r_rd      <= 1'b0;
            r_busy    <= 1'b0;
            r_strobe  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_ptr     <= w_ptr_nxt;
            r_oe      <= w_oe_nxt;
            r_rd      <= w_rd_nxt;
            r_busy    <= w_busy_nxt;
            r_strobe  <= w_strobe_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_ptr] <= w_byte;
        end
    end

    assign siod_oe   = r_oe;
    assign wr_strobe = r_strobe;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign busy      = r_busy;
    assign dbg_data  = r_mem[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_sccb_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sccb_responder
// Brief    : Scoreboard bench: a bus master pushes expected SIOD-pull and
//            register-write events; monitors pop and compare them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sccb_responder;

    localparam int c_Q = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       siod_in;
    logic       siod_oe;
    logic       wr_strobe;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] dbg_addr = 8'h00;
    logic [7:0] dbg_data;
    logic       busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_rise_cyc = 0;

    logic [15:0] exp_wr[$];
    bit          exp_slot[$];
    event        slot_ev;

    // Open-drain wired-AND between master and target.
    assign siod_in = m_sda & ~siod_oe;

    sccb_responder #(.DEVICE_ID(8'h42), .ADDR_W(8), .ACK_EN(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sioc_in   (m_scl),
        .siod_in   (siod_in),
        .siod_oe   (siod_oe),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .busy      (busy)
    );

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_q();
        repeat (c_Q) @(negedge clk);
    endtask

    task automatic scl_rise(input bit exp_oe);
        exp_slot.push_back(exp_oe);
        m_scl = 1'b1;
        last_rise_cyc = cyc;
        -> slot_ev;
    endtask

    task automatic send_bit(input bit b, input bit exp_oe);
        m_sda = b;
        wait_q();
        scl_rise(exp_oe);
        wait_q();
        wait_q();
        m_scl = 1'b0;
        wait_q();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit exp_ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i], 1'b0);
        send_bit(1'b1, exp_ack);
    endtask

    task automatic recv_byte(input logic [7:0] exp, input bit master_ack);
        for (int i = 7; i >= 0; i--) send_bit(1'b1, ~exp[i]);
        send_bit(~master_ack, 1'b0);
    endtask

    task automatic bus_start();
        m_sda = 1'b1;
        if (!m_scl) begin
            wait_q();
            scl_rise(1'b0);
        end
        wait_q();
        m_sda = 1'b0;
        wait_q();
        m_scl = 1'b0;
        wait_q();
    endtask

    task automatic bus_stop();
        m_sda = 1'b0;
        wait_q();
        scl_rise(1'b0);
        wait_q();
        m_sda = 1'b1;
        wait_q();
        wait_q();
    endtask

    task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
        bus_start();
        send_byte(8'h42, 1'b1);
        send_byte(a, 1'b1);
        exp_wr.push_back({a, d});
        send_byte(d, 1'b1);
        bus_stop();
    endtask

    task automatic peek(input string name, input logic [7:0] a, input logic [7:0] exp);
        dbg_addr = a;
        #1;
        check(name, dbg_data, exp);
    endtask

    // SIOD-pull monitor: one expectation per SIOC high phase.
    always begin
        @(slot_ev);
        repeat (c_Q) @(negedge clk);
        if (exp_slot.size() == 0) begin
            total++;
            bad++;
            $display("FAIL slot_unexpected: got oe=%0b with no expectation", siod_oe);
        end else begin
            check("slot_oe", siod_oe, exp_slot.pop_front());
        end
    end

    // Register-write monitor.
    always @(negedge clk) begin
        if (wr_strobe) begin
            if (exp_wr.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wr_unexpected: got addr=%0h data=%0h expected no write", wr_addr, wr_data);
            end else begin
                logic [15:0] e;
                e = exp_wr.pop_front();
                check("wr_addr", wr_addr, e[15:8]);
                check("wr_data", wr_data, e[7:0]);
                check("wr_latency", cyc - last_rise_cyc, 3);
            end
        end
    end

    initial begin
        repeat (400000) @(negedge clk);
        $display("FAIL timeout: got no finish expected finish within budget");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_oe", siod_oe, 0);
        check("rst_strobe", wr_strobe, 0);
        check("rst_addr", wr_addr, 0);
        check("rst_data", wr_data, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // T1 basic write
        bus_start();
        check("t1_busy_start", busy, 1);
        send_byte(8'h42, 1'b1);
        send_byte(8'h12, 1'b1);
        exp_wr.push_back({8'h12, 8'h80});
        send_byte(8'h80, 1'b1);
        bus_stop();
        check("t1_busy_stop", busy, 0);
        peek("t1_dbg", 8'h12, 8'h80);

        // T2 two-phase read
        write_reg(8'h3A, 8'hC5);
        bus_start();
        send_byte(8'h42, 1'b1);
        send_byte(8'h3A, 1'b1);
        bus_stop();
        bus_start();
        send_byte(8'h43, 1'b1);
        recv_byte(8'hC5, 1'b0);
        bus_stop();
        check("t2_busy", busy, 0);

        // T3 wrong device ID
        bus_start();
        send_byte(8'h60, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h55, 1'b0);
        bus_stop();
        peek("t3_dbg", 8'h12, 8'h80);

        // T4 burst with address wrap
        bus_start();
        send_byte(8'h42, 1'b1);
        send_byte(8'hFE, 1'b1);
        exp_wr.push_back({8'hFE, 8'h11});
        send_byte(8'h11, 1'b1);
        exp_wr.push_back({8'hFF, 8'h22});
        send_byte(8'h22, 1'b1);
        exp_wr.push_back({8'h00, 8'h33});
        send_byte(8'h33, 1'b1);
        bus_stop();
        peek("t4_fe", 8'hFE, 8'h11);
        peek("t4_ff", 8'hFF, 8'h22);
        peek("t4_00", 8'h00, 8'h33);

        // T5 abort mid data byte
        bus_start();
        send_byte(8'h42, 1'b1);
        send_byte(8'h40, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(i[0], 1'b0);
        bus_stop();
        check("t5_busy", busy, 0);
        write_reg(8'h40, 8'h9C);
        peek("t5_dbg", 8'h40, 8'h9C);

        // T6 reset while the target is driving a read zero
        write_reg(8'h20, 8'h7F);
        bus_start();
        send_byte(8'h42, 1'b1);
        send_byte(8'h20, 1'b1);
        bus_stop();
        bus_start();
        send_byte(8'h43, 1'b1);
        check("t6_oe_driving", siod_oe, 1);
        rst_n = 1'b0;
        #1;
        check("t6_oe_async", siod_oe, 0);
        check("t6_busy", busy, 0);
        m_sda = 1'b1;
        scl_rise(1'b0);
        repeat (3 * c_Q) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("t6_oe_after", siod_oe, 0);
        write_reg(8'h12, 8'h80);
        peek("t6_t1_dbg", 8'h12, 8'h80);

        repeat (4 * c_Q) @(negedge clk);
        check("end_wr_queue", exp_wr.size(), 0);
        check("end_slot_queue", exp_slot.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
